fifo_rd_stream: RTL



---
 rtl/fifo_rd_pkg.sv | 10 +
 rtl/fifo_rd_skid.sv | 55 +++++
 rtl/fifo_rd_stream.sv | 83 ++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types for the async FIFO read-side stream adapter.
package fifo_rd_pkg;

  // Entries in the prefetch buffer; covers one word in flight plus one waiting.
  localparam int BUF_DEPTH = 2;

  // Occupancy of the prefetch buffer, 0..BUF_DEPTH.
  typedef logic [1:0] buf_cnt_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry FIFO-ordered prefetch buffer. Entry 0 is always the head, so the
// output word comes straight from a register with no path from the input.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             rclk,
  input  logic             rrstn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output buf_cnt_t         cnt,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;

  // Push appends at the tail, pop shifts entry 1 into the head; both together keep order.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      cnt  <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= din;
          else             ent1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = ent0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer of the async FIFO: pops words, absorbs the one-cycle
// registered-RAM latency and re-presents them as a valid/ready stream with
// packet framing (m_last every PKT_LEN beats).
// Optional delivered-word counter pop_cnt is built when FIFO_RD_STAT_EN is defined.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             rclk,
  input  logic             rrstn,
  input  logic             clr,
  input  logic             rempty,
  input  logic [WIDTH-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
`ifdef FIFO_RD_STAT_EN
  ,
  output logic [CNT_W-1:0] pop_cnt
`endif
);

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(PKT_LEN - 1);
  localparam logic [2:0]       DEPTH     = 3'(BUF_DEPTH);

  buf_cnt_t         buf_cnt;
  logic             inflight;
  logic [2:0]       occ;
  logic             hs;
  logic [CNT_W-1:0] beat;

  // Credits: buffered words plus the one possibly still coming out of the RAM.
  assign occ = {1'b0, buf_cnt} + {2'b00, inflight};
  assign hs  = m_valid & m_ready;

  // A full credit pool may still pop when the head leaves this cycle.
  assign rinc = ~clr & ~rempty & ((occ < DEPTH) | ((occ == DEPTH) & hs));

  assign m_valid = (buf_cnt != 2'd0);
  assign m_last  = m_valid & (beat == BEAT_LAST);

  // Remember a pop so its data is captured when it appears on rdata next cycle.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) inflight <= 1'b0;
    else        inflight <= rinc;
  end

  // A word arriving during clr is dropped because the buffer's clr wins over push.
  fifo_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .rclk  (rclk),
    .rrstn (rrstn),
    .clr   (clr),
    .push  (inflight),
    .din   (rdata),
    .pop   (hs),
    .cnt   (buf_cnt),
    .dout  (m_data)
  );

  // Beat position inside the current packet; clr restarts framing.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn)                    beat <= '0;
    else if (clr)                  beat <= '0;
    else if (hs && beat == BEAT_LAST) beat <= '0;
    else if (hs)                   beat <= beat + 1'b1;
  end

`ifdef FIFO_RD_STAT_EN
  // Delivered-word statistic; survives clr and wraps naturally.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn)  pop_cnt <= '0;
    else if (hs) pop_cnt <= pop_cnt + 1'b1;
  end
`endif

endmodule
